// File: rtl/det4_sequencer.sv
// Exact 4x4 signed 8-bit determinant computed over 31 cycles with one 17x17 multiplier
// and one accumulator; 2x2 minors of the upper and lower row pairs are combined (Laplace).
module det4_sequencer #(
  parameter int ACC_W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] matrix,
  output logic         busy,
  output logic         done,
  output logic [7:0]   det,
  output logic         overflow
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MINOR   = 2'd1;
  localparam logic [1:0] COMBINE = 2'd2;
  localparam logic [1:0] FINISH  = 2'd3;

  logic [1:0]              state;
  logic [4:0]              step;
  logic [127:0]            mat;
  logic signed [ACC_W-1:0] acc;

  logic signed [7:0]  el [16];
  logic signed [16:0] minors [12];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_el
      assign el[gi] = mat[127-8*gi -: 8];
    end
  endgenerate

  logic [3:0]              midx;
  logic                    lower;
  logic [2:0]              pair;
  logic [1:0]              cx, cy, col_a, col_b;
  logic [3:0]              idx_a, idx_b, cidx;
  logic signed [16:0]      op_a, op_b;
  logic signed [33:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [16:0]      minor_val;
  logic                    sub;

  assign midx  = step[4:1];
  assign lower = (midx >= 4'd6);
  assign cidx  = 4'd11 - {1'b0, step[2:0]};

  always_comb begin
    pair = lower ? 3'(midx - 4'd6) : midx[2:0];
    case (pair)
      3'd0:    begin cx = 2'd0; cy = 2'd1; end
      3'd1:    begin cx = 2'd0; cy = 2'd2; end
      3'd2:    begin cx = 2'd0; cy = 2'd3; end
      3'd3:    begin cx = 2'd1; cy = 2'd2; end
      3'd4:    begin cx = 2'd1; cy = 2'd3; end
      default: begin cx = 2'd2; cy = 2'd3; end
    endcase
    // Even step forms top[x]*bot[y], odd step forms top[y]*bot[x]
    col_a = step[0] ? cy : cx;
    col_b = step[0] ? cx : cy;
    idx_a = (lower ? 4'd8 : 4'd0) + {2'b00, col_a};
    idx_b = (lower ? 4'd12 : 4'd4) + {2'b00, col_b};
    if (state == COMBINE) begin
      op_a = minors[step[2:0]];
      op_b = minors[cidx];
    end else begin
      op_a = {{9{el[idx_a][7]}}, el[idx_a]};
      op_b = {{9{el[idx_b][7]}}, el[idx_b]};
    end
  end

  assign prod      = op_a * op_b;
  assign prod_ext  = {{(ACC_W-34){prod[33]}}, prod};
  // The true minor always fits 17 bits, so modulo-2^17 subtraction is exact
  assign minor_val = acc[16:0] - prod[16:0];
  assign sub       = (step[2:0] == 3'd1) || (step[2:0] == 3'd4);

  always_ff @(posedge clk) begin
    if (state == MINOR && step[0])
      minors[midx] <= minor_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      acc      <= '0;
      mat      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      det      <= 8'h00;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mat   <= matrix;
            step  <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= MINOR;
          end
        end
        MINOR: begin
          if (!step[0])
            acc <= prod_ext;
          if (step == 5'd23) begin
            step  <= '0;
            state <= COMBINE;
          end else begin
            step <= step + 5'd1;
          end
        end
        COMBINE: begin
          if (step == 5'd0)
            acc <= prod_ext;
          else if (sub)
            acc <= acc - prod_ext;
          else
            acc <= acc + prod_ext;
          if (step == 5'd5) begin
            step  <= '0;
            state <= FINISH;
          end else begin
            step <= step + 5'd1;
          end
        end
        default: begin
          det      <= acc[7:0];
          overflow <= !((&acc[ACC_W-1:7]) || !(|acc[ACC_W-1:7]));
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det4_sequencer.sv
// Directed bench for det4_sequencer: hand-computed determinants, cycle-exact handshake,
// start-while-busy and mid-operation reset.
module tb_det4_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] matrix = '0;
  logic         busy, done, overflow;
  logic [7:0]   det;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] held_det = 8'h00;
  logic       held_ovf = 1'b0;

  det4_sequencer #(.ACC_W(40)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix(matrix),
    .busy(busy), .done(done), .det(det), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch m; optionally pulse start with alt at edge glitch (0 = none).
  task automatic run(input string name, input logic [127:0] m, input logic [127:0] alt,
                     input logic [7:0] exp_det, input logic exp_ovf, input int glitch);
    @(negedge clk); matrix = m; start = 1'b1;
    @(posedge clk); #1;
    chk({name, " E0 busy/done"}, {30'd0, busy, done}, 32'b10);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      start = (i == glitch);
      if (i == glitch) matrix = alt;
      @(posedge clk); #1;
      if (i < 31) begin
        chk({name, " busy/done mid"}, {30'd0, busy, done}, 32'b10);
        chk({name, " det held"}, {23'd0, overflow, det}, {23'd0, held_ovf, held_det});
      end
    end
    chk({name, " E31 busy/done"}, {30'd0, busy, done}, 32'b01);
    chk({name, " det"}, {24'd0, det}, {24'd0, exp_det});
    chk({name, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    held_det = exp_det;
    held_ovf = exp_ovf;
    @(posedge clk); #1;
    chk({name, " done one cycle"}, {31'd0, done}, 32'd0);
    chk({name, " det after"}, {23'd0, overflow, det}, {23'd0, held_ovf, held_det});
    $display("run %s: det=%h overflow=%b", name, det, overflow);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {21'd0, busy, done, overflow, det}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run("identity",  128'h01000000_00010000_00000100_00000001, '0, 8'h01, 1'b0, 0);
    run("diag2345",  128'h02000000_00030000_00000400_00000005, '0, 8'h78, 1'b0, 0);
    run("diag2346",  128'h02000000_00030000_00000400_00000006, '0, 8'h90, 1'b1, 0);
    run("diag-128",  128'h80000000_00800000_00008000_00000080, '0, 8'h00, 1'b1, 0);
    run("perm",      128'h02000000_00000100_00010000_000000FD, '0, 8'h06, 1'b0, 0);
    run("singular",  128'h01020304_01020304_05060708_090A0B0C, '0, 8'h00, 1'b0, 0);
    run("ignored",   128'h02000000_00030000_00000400_00000005,
                     128'h01000000_00010000_00000100_00000001, 8'h78, 1'b0, 10);

    // Launch, then reset asynchronously just after E15
    @(negedge clk); matrix = 128'h02000000_00030000_00000400_00000006; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset", {21'd0, busy, done, overflow, det}, 32'd0);
    held_det = 8'h00;
    held_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("no done after reset", {30'd0, busy, done}, 32'd0);
    end
    $display("run reset: busy=%b det=%h", busy, det);

    run("after reset", 128'h02000000_00030000_00000400_00000005, '0, 8'h78, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/det4_sequencer.md
# det4_sequencer

Multi-cycle, single-multiplier engine computing the exact determinant of a 4x4 signed 8-bit matrix for the arithmetic coprocessor. It replaces the fully combinational determinant datapath for area-constrained builds. A microsequenced FSM time-shares one signed 17x17 multiplier and one 40-bit accumulator over a fixed 30-step schedule. Operations are launched through a start/busy/done handshake driven by the coprocessor's operation dispatcher.

## Interface
Parameters:
- ACC_W, 40, accumulator width in bits; must be >= 38.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin; sampled only in IDLE.
- matrix  in  128  row-major operand: a=[127:120], b=[119:112] … p=[7:0]; each element is signed 8-bit.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when det/overflow are valid.
- det  out  8  signed result, the low 8 bits of the exact determinant; held until the next done.
- overflow  out  1  exact determinant lies outside [-128,127]; held with det.

## Operation
- Rows: r0=(a,b,c,d), r1=(e,f,g,h), r2=(i,j,k,l), r3=(m,n,o,p).
- Column pairs (x,y), in fixed order: (0,1),(0,2),(0,3),(1,2),(1,3),(2,3).
- Upper 2x2 minors: Sxy = r0[x]*r1[y] - r0[y]*r1[x].
- Lower 2x2 minors: Cxy = r2[x]*r3[y] - r2[y]*r3[x].
- Each minor is 17-bit signed, range ±32768, stored in a 12-entry minor register file.
- det = S01*C23 - S02*C13 + S03*C12 + S12*C03 - S13*C02 + S23*C01, exact in ACC_W bits. No wrap occurs anywhere before final truncation.
- FSM states: IDLE, MINOR, COMBINE, FINISH.
- IDLE:
  - If start=1: capture matrix into an internal register, clear step counter and accumulator, set busy=1, go to MINOR.
  - matrix is ignored after capture.
- MINOR, steps 0..23 (two steps per minor; S01..S23 first, then C01..C23):
  - Even step: acc = product.
  - Odd step: minor = acc - product, written to the register file.
- COMBINE, steps 0..5:
  - acc = acc ± S*C, with sign pattern +,-,+,+,-,+.
  - Step 0 loads the product into acc instead of adding.
- FINISH:
  - det = acc[7:0].
  - overflow = (acc > 127) || (acc < -128).
  - done=1, busy=0, return to IDLE.
- start while busy is ignored; it is not queued.
- start held high continuously relaunches on the cycle after done, using the matrix value present at that edge.
- Signed arithmetic throughout, with operands sign-extended before multiplying. -128*-128 = +16384 must be exact.

## Timing
- Reset values: busy=0, done=0, det=8'h00, overflow=0, state=IDLE, step=0, acc=0.
- Edge E0 accepts start. busy is high from E0 through E31, inclusive of the cycles between them.
- Edges E1..E24 execute MINOR steps; edges E25..E30 execute COMBINE steps.
- Edge E31 registers det/overflow, pulses done, and drops busy.
- Latency from start edge to done edge: 31 cycles. Throughput: one result per 32 cycles with start held high.
- done is high for exactly one cycle. det and overflow change only on the done edge.
- Reset asserted mid-operation: outputs take their reset values immediately. The in-flight result is discarded and no done is produced.
- Reset release while start=1: start is sampled on the first rising edge with rst low.

## Test plan
- Identity matrix, start pulse -> done exactly 31 cycles after the start edge; det=8'h01, overflow=0; busy high through E31.
- diag(2,3,4,5) -> det=8'h78 (120), overflow=0.
- diag(2,3,4,6) -> det=8'h90, overflow=1 (exact value 144).
- diag(-128,-128,-128,-128) -> exact value 2^28; det=8'h00, overflow=1. Checks that the minor/accumulator widths do not wrap.
- Rows (2,0,0,0), (0,0,1,0), (0,1,0,0), (0,0,0,-3) -> det=8'h06, overflow=0.
- Row r1 equal to r0 (singular) -> det=8'h00, overflow=0.
- Busy and reset handling, in sequence:
  - Launch a run, then pulse start again at E10 with a different matrix -> ignored; first result unchanged.
  - Assert rst at E15 -> busy=0 immediately, no done pulse, det keeps its reset value 8'h00.
  - Next start after reset -> normal 31-cycle run.
